// File: rtl/wrr_multi_dispatch.sv
// Weighted-round-robin issue arbiter: NUM_THREADS decode slots onto NUM_ALUS ALUs with a shared multi-cycle divider.
// Optional starvation aging is enabled by defining DISPATCH_AGING_EN.
module wrr_multi_dispatch #(
    parameter int unsigned       NUM_THREADS  = 4,
    parameter int unsigned       NUM_ALUS     = 2,
    parameter int unsigned       OPC_W        = 7,
    parameter logic [OPC_W-1:0]  DIV_OPC      = OPC_W'(38),
    parameter int unsigned       DIV_LAT      = 3,
    parameter int unsigned       WEIGHT_W     = 4,
    parameter int unsigned       DIV_BONUS    = 4,
    parameter int unsigned       STARTUP_HOLD = 2,
    parameter int unsigned       AGE_MAX      = 2,
    localparam int unsigned      TID_W        = $clog2(NUM_THREADS + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_THREADS-1:0][OPC_W-1:0]    oh_in,
    input  logic [NUM_ALUS-1:0]                  alu_ready,
    output logic [NUM_ALUS-1:0][TID_W-1:0]       dispatch_threads,
    output logic [NUM_ALUS-1:0]                  dispatch_valid,
    output logic                                 div_busy
);

    localparam int unsigned      CNT_W      = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam int unsigned      HOLD_W     = (STARTUP_HOLD > 0) ? $clog2(STARTUP_HOLD + 1) : 1;
    localparam int unsigned      W_MAX_I    = (2 ** WEIGHT_W) - 1;
    localparam logic [WEIGHT_W-1:0] W_MAX   = '1;
    localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(DIV_LAT - 1);

    function automatic logic [WEIGHT_W-1:0] sat_w(input int unsigned v);
        return (v > W_MAX_I) ? W_MAX : WEIGHT_W'(v);
    endfunction

    logic [HOLD_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    wait_cnt [NUM_THREADS];
    logic [WEIGHT_W-1:0] weight   [NUM_THREADS];
    logic [WEIGHT_W-1:0] ew_base  [NUM_THREADS];
    logic [NUM_THREADS-1:0] is_div;
    logic [NUM_THREADS-1:0] aged;
    logic [NUM_THREADS-1:0] taken;
    logic [NUM_THREADS-1:0] win;
    logic [WEIGHT_W-1:0] best;
    logic [WEIGHT_W-1:0] e;
    int unsigned         bsel;
    logic                div_taken;
    logic                any_grant;
    logic                div_grant;

`ifdef DISPATCH_AGING_EN
    localparam int unsigned AGE_W = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;
    logic [AGE_W-1:0] age [NUM_THREADS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_THREADS; i++) age[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                if (taken[i])
                    age[i] <= '0;
                else if (oh_in[i] != '0 && age[i] != AGE_W'(AGE_MAX))
                    age[i] <= age[i] + 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_THREADS; i++) aged[i] = (age[i] == AGE_W'(AGE_MAX));
    end
`else
    assign aged = '0;
`endif

    always_comb begin
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            is_div[i]  = (oh_in[i] == DIV_OPC);
            ew_base[i] = '0;
            if (oh_in[i] != '0 && wait_cnt[i] == '0) begin
                if (is_div[i]) begin
                    if (div_cnt == '0)
                        ew_base[i] = aged[i] ? W_MAX : sat_w(32'(weight[i]) + DIV_BONUS);
                end else begin
                    ew_base[i] = aged[i] ? W_MAX : weight[i];
                end
            end
        end
    end

    // Ports are served in order; earlier winners and an already-issued divide mask later ports.
    always_comb begin
        taken          = '0;
        div_taken      = 1'b0;
        dispatch_valid = '0;
        win            = '0;
        best           = '0;
        e              = '0;
        bsel           = 0;
        for (int unsigned j = 0; j < NUM_ALUS; j++) begin
            dispatch_threads[j] = TID_W'(NUM_THREADS);
            win  = '0;
            best = '0;
            bsel = 0;
            if (hold_cnt == '0 && alu_ready[j]) begin
                for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                    e = ew_base[i];
                    if (taken[i] || (is_div[i] && div_taken)) e = '0;
                    if (e > best) begin
                        best   = e;
                        bsel   = i;
                        win    = '0;
                        win[i] = 1'b1;
                    end
                end
                if (best != '0) begin
                    dispatch_valid[j]   = 1'b1;
                    dispatch_threads[j] = TID_W'(bsel);
                    taken               = taken | win;
                    if ((win & is_div) != '0) div_taken = 1'b1;
                end
            end
        end
    end

    assign any_grant = (dispatch_valid != '0);
    assign div_grant = div_taken;
    assign div_busy  = (div_cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= HOLD_W'(STARTUP_HOLD);
            div_cnt  <= '0;
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                wait_cnt[i] <= '0;
                weight[i]   <= sat_w(2 * (NUM_THREADS - i) - 1);
            end
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end else begin
            // A divide grant reloads even when the old occupancy expires this cycle.
            if (div_grant)
                div_cnt <= DIV_RELOAD;
            else if (div_cnt != '0)
                div_cnt <= div_cnt - 1'b1;
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                if (taken[i] && is_div[i])
                    wait_cnt[i] <= DIV_RELOAD;
                else if (wait_cnt[i] != '0)
                    wait_cnt[i] <= wait_cnt[i] - 1'b1;
            end
            if (any_grant) begin
                weight[0] <= weight[NUM_THREADS-1];
                for (int unsigned i = 1; i < NUM_THREADS; i++) weight[i] <= weight[i-1];
            end
        end
    end

endmodule

// File: tb/tb_wrr_multi_dispatch.sv
// Table-driven scoreboard bench for wrr_multi_dispatch (2-ALU instance) plus a 1-ALU rotation/aging sequence.
module tb_wrr_multi_dispatch;

    localparam int unsigned NT = 4;
    localparam int unsigned NA = 2;
    localparam int unsigned OW = 7;
    localparam int unsigned TW = 3;
    localparam logic [OW-1:0] A = 7'd1;
    localparam logic [OW-1:0] D = 7'd38;
    localparam logic [OW-1:0] Z = 7'd0;
    localparam logic [TW-1:0] I = 3'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst;
    logic [NT-1:0][OW-1:0]     oh_in;
    logic [NA-1:0]             alu_ready;
    logic [NA-1:0][TW-1:0]     dispatch_threads;
    logic [NA-1:0]             dispatch_valid;
    logic                      div_busy;

    logic                      rst_b;
    logic [NT-1:0][OW-1:0]     oh_b;
    logic [0:0]                rdy_b;
    logic [0:0][TW-1:0]        thr_b;
    logic [0:0]                vld_b;
    logic                      busy_b;

    wrr_multi_dispatch #(.NUM_THREADS(4), .NUM_ALUS(2), .DIV_LAT(3)) dut (
        .clk(clk), .rst(rst), .oh_in(oh_in), .alu_ready(alu_ready),
        .dispatch_threads(dispatch_threads), .dispatch_valid(dispatch_valid), .div_busy(div_busy)
    );

    wrr_multi_dispatch #(.NUM_THREADS(4), .NUM_ALUS(1), .DIV_LAT(3), .AGE_MAX(2)) dut1 (
        .clk(clk), .rst(rst_b), .oh_in(oh_b), .alu_ready(rdy_b),
        .dispatch_threads(thr_b), .dispatch_valid(vld_b), .div_busy(busy_b)
    );

    typedef struct {
        logic                  r;
        logic [NT-1:0][OW-1:0] oh;
        logic [NA-1:0]         rdy;
        logic [NA-1:0][TW-1:0] thr;
        logic [NA-1:0]         vld;
        logic                  busy;
    } vec_t;

    typedef struct {
        int unsigned           id;
        logic                  one_alu;
        logic [NA-1:0][TW-1:0] thr;
        logic [NA-1:0]         vld;
        logic                  busy;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic r, input logic [OW-1:0] o0, o1, o2, o3,
                                input logic [1:0] rdy, input logic [TW-1:0] t0, t1,
                                input logic [1:0] vld, input logic busy);
        vec_t v;
        v.r    = r;
        v.oh   = {o3, o2, o1, o0};
        v.rdy  = rdy;
        v.thr  = {t1, t0};
        v.vld  = vld;
        v.busy = busy;
        return v;
    endfunction

    task automatic check_one();
        exp_t x;
        logic [NA-1:0][TW-1:0] at;
        logic [NA-1:0]         av;
        logic                  ab;
        n_vec++;
        if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard: empty queue at vector %0d, expected an entry", n_vec);
            return;
        end
        x = sb.pop_front();
        if (x.one_alu) begin
            at = {I, thr_b[0]};
            av = {1'b0, vld_b[0]};
            ab = busy_b;
        end else begin
            at = dispatch_threads;
            av = dispatch_valid;
            ab = div_busy;
        end
        if (at !== x.thr || av !== x.vld || ab !== x.busy) begin
            n_miss++;
            $display("FAIL %s#%0d: thr1=%0d thr0=%0d valid=%b busy=%b, expected thr1=%0d thr0=%0d valid=%b busy=%b",
                     x.one_alu ? "aging" : "vec", x.id, at[1], at[0], av, ab,
                     x.thr[1], x.thr[0], x.vld, x.busy);
        end
    endtask

    initial begin
        logic [TW-1:0] exp_b [6];

        rst = 1'b0; oh_in = '0; alu_ready = '0;
        rst_b = 1'b0; oh_b = '0; rdy_b = '0;

        // rotation with all ADDs
        vt.push_back(mk(0, A, A, A, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b11, 0, 1, 2'b11, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b11, 1, 2, 2'b11, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b11, 2, 3, 2'b11, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b11, 3, 0, 2'b11, 0));
        // one divide, occupancy and re-grant
        vt.push_back(mk(0, A, A, D, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, D, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, D, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, D, A, 2'b11, 0, 2, 2'b11, 0));
        vt.push_back(mk(1, A, A, D, A, 2'b11, 1, 3, 2'b11, 1));
        vt.push_back(mk(1, A, A, D, A, 2'b11, 3, 0, 2'b11, 1));
        vt.push_back(mk(1, Z, Z, D, Z, 2'b11, 2, I, 2'b01, 0));
        vt.push_back(mk(1, Z, Z, D, Z, 2'b11, I, I, 2'b00, 1));
        vt.push_back(mk(1, Z, Z, D, Z, 2'b11, I, I, 2'b00, 1));
        vt.push_back(mk(1, Z, Z, D, Z, 2'b11, 2, I, 2'b01, 0));
        // two divides competing in the same cycle
        vt.push_back(mk(0, D, D, A, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, D, D, A, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, D, D, A, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, D, D, A, A, 2'b11, 0, 2, 2'b11, 0));
        vt.push_back(mk(1, D, D, A, A, 2'b11, 2, 3, 2'b11, 1));
        vt.push_back(mk(1, D, D, A, A, 2'b11, 2, 3, 2'b11, 1));
        vt.push_back(mk(1, D, D, A, A, 2'b11, 0, 3, 2'b11, 0));
        // backpressure and empty cycles do not rotate
        vt.push_back(mk(0, A, A, A, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b01, 0, I, 2'b01, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b01, 1, I, 2'b01, 0));
        vt.push_back(mk(1, Z, Z, Z, Z, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b11, 2, 3, 2'b11, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b00, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b10, I, 3, 2'b10, 0));
        // reset while the divider is busy
        vt.push_back(mk(0, A, A, D, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, D, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, D, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, D, A, 2'b11, 0, 2, 2'b11, 0));
        vt.push_back(mk(1, A, A, D, A, 2'b11, 1, 3, 2'b11, 1));
        vt.push_back(mk(0, A, A, A, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b11, I, I, 2'b00, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b11, 0, 1, 2'b11, 0));
        vt.push_back(mk(1, A, A, A, A, 2'b11, 1, 2, 2'b11, 0));

        foreach (vt[k]) begin
            @(posedge clk); #1;
            rst       = vt[k].r;
            oh_in     = vt[k].oh;
            alu_ready = vt[k].rdy;
            sb.push_back('{id: k, one_alu: 1'b0, thr: vt[k].thr, vld: vt[k].vld, busy: vt[k].busy});
            @(negedge clk);
            check_one();
        end

        // single-ALU instance: four ADD requesters, with and without aging
        exp_b[0] = I; exp_b[1] = I; exp_b[2] = 3'd0; exp_b[3] = 3'd1; exp_b[4] = 3'd2;
`ifdef DISPATCH_AGING_EN
        exp_b[5] = 3'd0;
`else
        exp_b[5] = 3'd3;
`endif
        @(posedge clk); #1;
        rst_b = 1'b0; oh_b = {A, A, A, A}; rdy_b = 1'b1;
        sb.push_back('{id: 99, one_alu: 1'b1, thr: {I, I}, vld: 2'b00, busy: 1'b0});
        @(negedge clk);
        check_one();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            rst_b = 1'b1;
            sb.push_back('{id: c, one_alu: 1'b1, thr: {I, exp_b[c]},
                           vld: {1'b0, (exp_b[c] != I)}, busy: 1'b0});
            @(negedge clk);
            check_one();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
